uart_boot_loader: RTL

- Upstream of the softcore's instruction memory.
- Receives a program image over a UART serial line and assembles bytes into 32-bit little-endian instruction words.
- Issues one write per word into instruction memory.
- Holds the core in reset until the whole image is loaded; a bad image keeps the core held.

---
 rtl/uart_boot_loader.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a program image over an 8N1 UART line, packs the
// bytes into 32-bit little-endian words, writes them to instruction memory and
// releases the core once the whole image has arrived.
// Image: LEN_LO, LEN_HI (word count N), then 4N data bytes, LSB first.
// Optional macro BOOT_LOADER_CHECKSUM_EN: one trailer byte must equal the XOR
// of all data bytes before the core is released.
module uart_boot_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned MAX_WORDS    = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        uart_rx_i,
    output logic        imem_write_enable_o,
    output logic [31:0] imem_address_o,
    output logic [31:0] imem_data_o,
    output logic        core_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERROR
`ifdef BOOT_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    // ------------------------------------------------------------------
    // RX front end
    // ------------------------------------------------------------------
    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] bit_clk;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid, frame_err;
    logic             bit_tick;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection;
    // all reset to the idle-high level so reset release never looks like a start bit.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (!reset_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // The start bit is checked at half a bit period, data and stop bits one
    // full period apart after that, so every sample lands mid-bit.
    assign bit_tick = (rx_state == R_START) ? (bit_clk == HALF_BIT) : (bit_clk == FULL_BIT);

    // Receiver state register.
    always_ff @(posedge clk_i) begin
        if (!reset_i) rx_state <= R_IDLE;
        else          rx_state <= rx_next;
    end

    // Receiver next-state: a start bit that reads high at mid-bit was a glitch.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned and no latch is inferred.
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_prev && !rx_sync)        rx_next = R_START;
            R_START: if (bit_tick)                   rx_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = R_STOP;
            R_STOP:  if (bit_tick)                   rx_next = R_IDLE;
            default:                                 rx_next = R_IDLE;
        endcase
    end

    // Bit timer, LSB-first shift register and the one-cycle byte/framing pulses.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            bit_clk    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_state == R_IDLE || bit_tick) bit_clk <= '0;
            else                                bit_clk <= bit_clk + 1'b1;
            case (rx_state)
                R_START: if (bit_tick) bit_idx <= '0;
                R_DATA: begin
                    if (bit_tick) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                    end
                end
                R_STOP: begin
                    if (bit_tick) begin
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Image loader
    // ------------------------------------------------------------------
    state_t      state, state_next;
    logic [7:0]  len_lo;
    logic [15:0] word_len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_q;
    logic [31:0] addr_q, data_q;
    logic [15:0] len_word;
    logic        len_ok;
    logic        last_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign len_word  = {rx_shift, len_lo};
    assign len_ok    = (len_word != 16'd0) && ({16'd0, len_word} <= MAX_WORDS);
    assign last_word = (word_idx + 16'd1 == word_len);

    // Loader state register.
    always_ff @(posedge clk_i) begin
        if (!reset_i) state <= S_LEN0;
        else          state <= state_next;
    end

    // Loader next-state and status outputs; a framing error aborts any load in flight.
    always_comb begin
        state_next          = state;
        imem_write_enable_o = 1'b0;
        busy_o              = 1'b0;
        done_o              = 1'b0;
        error_o             = 1'b0;
        core_reset_o        = 1'b0;
        case (state)
            S_LEN0: if (byte_valid) state_next = S_LEN1;
            S_LEN1: begin
                busy_o = 1'b1;
                if (byte_valid) state_next = len_ok ? S_DATA : S_ERROR;
            end
            S_DATA: begin
                busy_o = 1'b1;
                if (byte_valid && byte_idx == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                busy_o              = 1'b1;
                imem_write_enable_o = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                state_next = last_word ? S_CHECK : S_DATA;
`else
                state_next = last_word ? S_DONE : S_DATA;
`endif
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHECK: begin
                busy_o = 1'b1;
                if (byte_valid) state_next = (rx_shift == csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                done_o       = 1'b1;
                core_reset_o = 1'b1;
            end
            S_ERROR: error_o = 1'b1;
            default: state_next = S_ERROR;
        endcase
        if (frame_err && state != S_DONE && state != S_ERROR) state_next = S_ERROR;
    end

    // Length capture, byte packing and the address/data registers that hold
    // the last written word between strobes.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            len_lo   <= '0;
            word_len <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                S_LEN0: if (byte_valid) len_lo <= rx_shift;
                S_LEN1: begin
                    if (byte_valid) begin
                        word_len <= len_word;
                        word_idx <= '0;
                        byte_idx <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_DATA: begin
                    if (byte_valid) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        csum     <= csum ^ rx_shift;
`endif
                        case (byte_idx)
                            2'd0: word_q[7:0]   <= rx_shift;
                            2'd1: word_q[15:8]  <= rx_shift;
                            2'd2: word_q[23:16] <= rx_shift;
                            default: begin
                                addr_q <= {14'd0, word_idx, 2'b00};
                                data_q <= {rx_shift, word_q};
                            end
                        endcase
                    end
                end
                S_WRITE: word_idx <= word_idx + 16'd1;
                default: ;
            endcase
        end
    end

    assign imem_address_o = addr_q;
    assign imem_data_o    = data_q;

endmodule
